counter_scheduler: RTL and testbench

Time-shares one up-counter among `NUM_REQ` requesters, each asking for a count of its own length. Grants one requester at a time using round-robin priority and runs the counter from 0 to that requester's target. Signals completion with a one-cycle `done` pulse, then re-arbitrates. Sits between client blocks and the counter datapath and owns its sequencing: clear, run, stop.

---
 rtl/counter_scheduler_pkg.sv | 13 +
 rtl/counter_scheduler_if.sv | 18 +
 rtl/counter_scheduler_rr_arbiter.sv | 36 +++
 rtl/counter_scheduler.sv | 141 ++++++++++++++
 tb/tb_counter_scheduler.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_scheduler_pkg.sv
// Shared types and default sizing for the counter scheduler.
package counter_sched_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/counter_scheduler_if.sv
// Client-side bundle of the counter scheduler: requests and targets in,
// grant/busy/count/done back out.
interface counter_scheduler_if #(
  parameter int NUM_REQ   = counter_sched_pkg::DEF_NUM_REQ,
  parameter int CNT_WIDTH = counter_sched_pkg::DEF_CNT_WIDTH
);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*CNT_WIDTH-1:0] target;
  logic [NUM_REQ-1:0]           grant;
  logic                         busy;
  logic [CNT_WIDTH-1:0]         count;
  logic [NUM_REQ-1:0]           done;

  modport master (output req, target, input grant, busy, count, done);
  modport slave  (input req, target, output grant, busy, count, done);

endinterface

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// above ptr, searching upward with wrap. Independent of the scheduler.
module rr_arbiter #(
  parameter int  N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW:0]   jw;
  logic [IW-1:0] j;

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    jw    = '0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      jw = {1'b0, ptr} + (IW+1)'(i);
      if (jw >= (IW+1)'(N)) jw = jw - (IW+1)'(N);
      j = jw[IW-1:0];
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Time-shares one up-counter among NUM_REQ requesters with round-robin
// arbitration. Optional feature macro: COUNTER_SCHEDULER_ABORT_EN (owner
// dropping req during RUN abandons the job without a done pulse).
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   IDLE    | no owner; arbitrate on req, grant at next edge
//   RUN     | counting from 0 up to the latched target
//   DONE    | count == target; done pulse to owner for one cycle
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  counter_scheduler_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] tgt_q, tgt_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        owner_q, owner_d;

  logic [NUM_REQ-1:0]   win_gnt;
  logic [IW-1:0]        win_idx;
  logic                 win_valid;
  logic [IW-1:0]        ptr_nxt;
  logic [CNT_WIDTH-1:0] tgt_arr [NUM_REQ];

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .gnt   (win_gnt),
    .idx   (win_idx),
    .valid (win_valid)
  );

  // Split the flat target bus into per-requester slices.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      tgt_arr[i] = bus.target[i*CNT_WIDTH +: CNT_WIDTH];
    end
  end

  // The owner just served drops to lowest priority.
  assign ptr_nxt = (owner_q == IW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    count_d = count_q;
    tgt_d   = tgt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_RUN;
          grant_d = win_gnt;
          busy_d  = 1'b1;
          count_d = '0;
          tgt_d   = tgt_arr[win_idx];
          owner_d = win_idx;
        end
      end
      ST_RUN: begin
        // Terminal count wins over an abort seen in the same cycle.
        if (count_q == tgt_q) begin
          state_d = ST_DONE;
          done_d  = grant_q;
        end
`ifdef COUNTER_SCHEDULER_ABORT_EN
        else if (!bus.req[owner_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_nxt;
        end
        else begin
          count_d = count_q + 1'b1;
        end
`else
        else begin
          count_d = count_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = ptr_nxt;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      tgt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      tgt_q   <= tgt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Self-checking bench for counter_scheduler: directed scenarios plus a
// randomized run against a job-level reference model.
module tb_counter_scheduler;

  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tgts [N];

  counter_scheduler_if #(.NUM_REQ(N), .CNT_WIDTH(W)) bus ();

  counter_scheduler #(.NUM_REQ(N), .CNT_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] pack_tgts(input int t0, input int t1, input int t2, input int t3);
    return {W'(t3), W'(t2), W'(t1), W'(t0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.target = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.target = '0;
    step();
    n_cmp++; if (bus.grant !== 4'b0) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.done !== 4'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0000", bus.done); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_job();
    bus.target = pack_tgts(3, 0, 0, 0);
    bus.req = 4'b0001;
    step();
    n_cmp++; if (bus.grant !== 4'b0001) begin n_bad++; $display("FAIL single_grant: got %b want 0001", bus.grant); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL single_count0: got %0d want 0", bus.count); end
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++; if (bus.count !== 4'(k)) begin n_bad++; $display("FAIL single_count: got %0d want %0d", bus.count, k); end
      n_cmp++; if (bus.done !== 4'b0) begin n_bad++; $display("FAIL single_early_done: got %b want 0000", bus.done); end
    end
    step();
    n_cmp++; if (bus.done !== 4'b0001) begin n_bad++; $display("FAIL single_done: got %b want 0001", bus.done); end
    n_cmp++; if (bus.count !== 4'd3) begin n_bad++; $display("FAIL single_done_count: got %0d want 3", bus.count); end
    n_cmp++; if (bus.grant !== 4'b0001) begin n_bad++; $display("FAIL single_done_grant: got %b want 0001", bus.grant); end
    bus.req = '0;
    step();
    n_cmp++; if (bus.grant !== 4'b0) begin n_bad++; $display("FAIL single_release: got %b want 0000", bus.grant); end
    n_cmp++; if (bus.done !== 4'b0) begin n_bad++; $display("FAIL single_done_width: got %b want 0000", bus.done); end
    n_cmp++; if (bus.count !== 4'd3) begin n_bad++; $display("FAIL single_count_hold: got %0d want 3", bus.count); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_g;
    do_reset();
    bus.target = pack_tgts(1, 1, 1, 1);
    bus.req = 4'b1111;
    step();
    for (int j = 0; j < 5; j++) begin
      exp_g = 4'b0001 << (j % 4);
      n_cmp++; if (bus.grant !== exp_g) begin n_bad++; $display("FAIL contention_grant: job %0d got %b want %b", j, bus.grant, exp_g); end
      repeat (3) step();
      n_cmp++; if (bus.grant !== 4'b0) begin n_bad++; $display("FAIL contention_gap: job %0d got %b want 0000", j, bus.grant); end
      step();
    end
    bus.req = '0;
  endtask

  task automatic test_boundary();
    do_reset();
    bus.target = pack_tgts(0, 0, 0, 0);
    bus.req = 4'b0001;
    step();
    n_cmp++; if (bus.grant !== 4'b0001 || bus.count !== 4'd0 || bus.done !== 4'b0) begin
      n_bad++; $display("FAIL tgt0_run: grant %b count %0d done %b want 0001/0/0000", bus.grant, bus.count, bus.done); end
    step();
    n_cmp++; if (bus.done !== 4'b0001 || bus.count !== 4'd0) begin
      n_bad++; $display("FAIL tgt0_done: done %b count %0d want 0001/0", bus.done, bus.count); end
    bus.req = '0;
    step();
    bus.target = pack_tgts(15, 0, 0, 0);
    bus.req = 4'b0001;
    step();
    for (int k = 0; k <= 15; k++) begin
      n_cmp++; if (bus.count !== 4'(k) || bus.done !== 4'b0) begin
        n_bad++; $display("FAIL tgt15_count: count %0d done %b want %0d/0000", bus.count, bus.done, k); end
      step();
    end
    n_cmp++; if (bus.done !== 4'b0001 || bus.count !== 4'd15) begin
      n_bad++; $display("FAIL tgt15_done: done %b count %0d want 0001/15", bus.done, bus.count); end
    bus.req = '0;
    step();
    n_cmp++; if (bus.grant !== 4'b0 || bus.count !== 4'd15) begin
      n_bad++; $display("FAIL tgt15_idle: grant %b count %0d want 0000/15", bus.grant, bus.count); end
  endtask

  task automatic test_target_change();
    do_reset();
    bus.target = pack_tgts(5, 0, 0, 0);
    bus.req = 4'b0001;
    step();
    bus.target = pack_tgts(2, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      n_cmp++; if (bus.count !== 4'(k) || bus.done !== 4'b0) begin
        n_bad++; $display("FAIL tchange_count: count %0d done %b want %0d/0000", bus.count, bus.done, k); end
    end
    step();
    n_cmp++; if (bus.done !== 4'b0001 || bus.count !== 4'd5) begin
      n_bad++; $display("FAIL tchange_done: done %b count %0d want 0001/5", bus.done, bus.count); end
    bus.req = '0;
    step();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    bus.target = pack_tgts(0, 0, 7, 0);
    bus.req = 4'b0010;
    repeat (2) step();
    bus.req = '0;
    step();
    bus.req = 4'b0100;
    step();
    n_cmp++; if (bus.grant !== 4'b0100) begin n_bad++; $display("FAIL midrst_grant: got %b want 0100", bus.grant); end
    repeat (2) step();
    n_cmp++; if (bus.count !== 4'd2) begin n_bad++; $display("FAIL midrst_count: got %0d want 2", bus.count); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.grant !== 4'b0 || bus.busy !== 1'b0 || bus.count !== 4'd0 || bus.done !== 4'b0) begin
      n_bad++; $display("FAIL midrst_clear: grant %b busy %b count %0d done %b want all 0", bus.grant, bus.busy, bus.count, bus.done); end
    step();
    n_cmp++; if (bus.done !== 4'b0) begin n_bad++; $display("FAIL midrst_nodone: got %b want 0000", bus.done); end
    rst = 1'b0;
    bus.target = pack_tgts(3, 3, 3, 3);
    bus.req = 4'b1111;
    step();
    n_cmp++; if (bus.grant !== 4'b0001 || bus.count !== 4'd0) begin
      n_bad++; $display("FAIL midrst_regrant: grant %b count %0d want 0001/0", bus.grant, bus.count); end
    bus.req = '0;
  endtask

`ifdef COUNTER_SCHEDULER_ABORT_EN
  task automatic test_abort();
    do_reset();
    bus.target = pack_tgts(5, 5, 5, 5);
    bus.req = 4'b0110;
    step();
    n_cmp++; if (bus.grant !== 4'b0010) begin n_bad++; $display("FAIL abort_grant: got %b want 0010", bus.grant); end
    step();
    n_cmp++; if (bus.count !== 4'd1) begin n_bad++; $display("FAIL abort_count: got %0d want 1", bus.count); end
    bus.req = 4'b0100;
    step();
    n_cmp++; if (bus.grant !== 4'b0 || bus.done !== 4'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle: grant %b done %b busy %b want 0000/0000/0", bus.grant, bus.done, bus.busy); end
    step();
    n_cmp++; if (bus.grant !== 4'b0100) begin n_bad++; $display("FAIL abort_next: got %b want 0100", bus.grant); end
    bus.req = '0;
  endtask
`endif

  // Job-level model: a job with target T holds the grant for T+2 cycles
  // (count = min(age, T), done at age T+1), then one idle cycle follows.
  task automatic test_random();
    bit         m_act = 1'b0;
    logic [1:0] m_own = '0;
    logic [1:0] m_ptr = '0;
    logic [1:0] w;
    int         m_tgt = 0;
    int         m_age = 0;
    int         m_cnt = 0;
    logic [3:0] r;
    int         t_at [N];
    logic [3:0] e_g, e_d;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.req = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++)
        tgts[i] = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 5));
      bus.target = pack_tgts(tgts[0], tgts[1], tgts[2], tgts[3]);
      r = bus.req;
      t_at = tgts;
      step();
      if (!m_act) begin
        if (r != 4'b0) begin
          for (int i = 3; i >= 0; i--) begin
            w = m_ptr + 2'(i);
            if (r[w]) m_own = w;
          end
          m_act = 1'b1;
          m_tgt = t_at[m_own];
          m_age = 0;
          m_cnt = 0;
        end
      end else begin
`ifdef COUNTER_SCHEDULER_ABORT_EN
        if (m_age < m_tgt && !r[m_own]) begin
          m_act = 1'b0;
          m_ptr = m_own + 2'd1;
        end else
`endif
        begin
          m_age++;
          if (m_age == m_tgt + 2) begin
            m_act = 1'b0;
            m_ptr = m_own + 2'd1;
          end else if (m_age <= m_tgt) begin
            m_cnt = m_age;
          end
        end
      end
      e_g = m_act ? (4'b0001 << m_own) : 4'b0;
      e_d = (m_act && m_age == m_tgt + 1) ? (4'b0001 << m_own) : 4'b0;
      n_cmp++; if (bus.grant !== e_g) begin n_bad++; $display("FAIL rand_grant: cycle %0d got %b want %b", c, bus.grant, e_g); end
      n_cmp++; if (bus.done !== e_d) begin n_bad++; $display("FAIL rand_done: cycle %0d got %b want %b", c, bus.done, e_d); end
      n_cmp++; if (bus.busy !== m_act) begin n_bad++; $display("FAIL rand_busy: cycle %0d got %b want %b", c, bus.busy, m_act); end
      n_cmp++; if (bus.count !== 4'(m_cnt)) begin n_bad++; $display("FAIL rand_count: cycle %0d got %0d want %0d", c, bus.count, m_cnt); end
    end
    bus.req = '0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.target = '0;
    test_reset();
    test_single_job();
    test_contention();
    test_boundary();
    test_target_change();
    test_reset_mid_run();
`ifdef COUNTER_SCHEDULER_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
